// File: rtl/qam16_pkg.sv
// qam16_pkg: shared definitions for the 16-QAM mapper in the OFDM transmit chain.
//   - DW_DEFAULT / NSC_DEFAULT / AMP_DEFAULT : chain-wide defaults
//   - state_t                                : byte-buffer FSM encoding
//   - lvl_m3/lvl_m1/lvl_p1/lvl_p3            : Gray levels as functions of AMP
//   - LVL_M3/LVL_M1/LVL_P1/LVL_P3            : the same levels at AMP_DEFAULT
package qam16_pkg;

   localparam int DW_DEFAULT  = 16;
   localparam int NSC_DEFAULT = 8;
   localparam int AMP_DEFAULT = 4096;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // no byte buffered
      HAVE2 = 2'd1,   // byte buffered, neither nibble emitted
      HAVE1 = 2'd2    // first nibble emitted, second pending
   } state_t;

   function automatic int lvl_m3(input int amp); return -3 * amp; endfunction
   function automatic int lvl_m1(input int amp); return -amp;     endfunction
   function automatic int lvl_p1(input int amp); return amp;      endfunction
   function automatic int lvl_p3(input int amp); return 3 * amp;  endfunction

   localparam int LVL_M3 = -3 * AMP_DEFAULT;
   localparam int LVL_M1 = -AMP_DEFAULT;
   localparam int LVL_P1 = AMP_DEFAULT;
   localparam int LVL_P3 = 3 * AMP_DEFAULT;

endpackage

// File: rtl/qam16_gray_lut.sv
// qam16_gray_lut: combinational Gray-coded 2-bit -> level map for one axis.
//   pair  (in, 2)  : Gray bit pair
//   level (out, DW): signed level; 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A
// Levels are elaboration-time constants; no multiplier is built.
module qam16_gray_lut
   import qam16_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int AMP = AMP_DEFAULT
) (
   input  logic [1:0]           pair,
   output logic signed [DW-1:0] level
);

   localparam logic signed [DW-1:0] M3 = DW'(lvl_m3(AMP));
   localparam logic signed [DW-1:0] M1 = DW'(lvl_m1(AMP));
   localparam logic signed [DW-1:0] P1 = DW'(lvl_p1(AMP));
   localparam logic signed [DW-1:0] P3 = DW'(lvl_p3(AMP));

   always_comb begin
      level = M3;
      case (pair)
         2'b00: level = M3;
         2'b01: level = M1;
         2'b11: level = P1;
         2'b10: level = P3;
         default: level = M3;
      endcase
   end

endmodule

// File: rtl/qam16_mapper.sv
// qam16_mapper: byte -> two Gray-coded 16-QAM subcarrier symbols.
//   aclk, reset (sync, active-high)
//   in_data[7:0], in_valid, in_ready         : byte input handshake
//   out_i, out_q (DW signed), out_idx, out_last,
//   out_valid, out_ready                      : symbol output handshake
// Each nibble b3b2b1b0 maps I from b3b2 and Q from b1b0. out_idx counts
// symbols within an OFDM symbol of NSC subcarriers; out_last marks NSC-1.
// Optional macro QAM16_LSB_FIRST_EN: emit nibble [3:0] before [7:4]
// (default emits [7:4] first).
module qam16_mapper
   import qam16_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int AMP = AMP_DEFAULT,
   parameter int NSC = NSC_DEFAULT,
   localparam int IW = $clog2(NSC)
) (
   input  logic                 aclk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic signed [DW-1:0] out_i,
   output logic signed [DW-1:0] out_q,
   output logic [IW-1:0]        out_idx,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready
);

   state_t               state;
   logic [7:0]           byte_q;
   logic [IW-1:0]        cnt;       // completed output handshakes mod NSC
   logic [IW-1:0]        cnt_now;   // index for a symbol loaded this edge
   logic                 adv, in_hs, out_hs;
   logic [3:0]           nib_first, nib_second, nib_sel;
   logic signed [DW-1:0] lvl_i, lvl_q;

   assign adv    = !out_valid || out_ready;
   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         EMPTY:   in_ready = 1'b1;
         HAVE2:   in_ready = 1'b0;
         HAVE1:   in_ready = adv;
         default: in_ready = 1'b0;
      endcase
   end

`ifdef QAM16_LSB_FIRST_EN
   assign nib_first  = byte_q[3:0];
   assign nib_second = byte_q[7:4];
`else
   assign nib_first  = byte_q[7:4];
   assign nib_second = byte_q[3:0];
`endif

   assign nib_sel = (state == HAVE2) ? nib_first : nib_second;

   qam16_gray_lut #(.DW(DW), .AMP(AMP)) u_lut_i (.pair(nib_sel[3:2]), .level(lvl_i));
   qam16_gray_lut #(.DW(DW), .AMP(AMP)) u_lut_q (.pair(nib_sel[1:0]), .level(lvl_q));

   // A symbol loaded on the same edge as a handshake takes the post-handshake
   // count, so indices stay continuous across bubbles.
   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] c);
      return (c == IW'(NSC - 1)) ? '0 : c + IW'(1);
   endfunction

   assign cnt_now = out_hs ? wrap_inc(cnt) : cnt;

   always_ff @(posedge aclk) begin
      if (reset) begin
         state     <= EMPTY;
         byte_q    <= '0;
         cnt       <= '0;
         out_i     <= '0;
         out_q     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (out_hs)
            cnt <= wrap_inc(cnt);

         if (adv && state != EMPTY) begin
            out_i     <= lvl_i;
            out_q     <= lvl_q;
            out_idx   <= cnt_now;
            out_last  <= (cnt_now == IW'(NSC - 1));
            out_valid <= 1'b1;
         end

         case (state)
            EMPTY: begin
               if (adv)
                  out_valid <= 1'b0;
               if (in_hs) begin
                  byte_q <= in_data;
                  state  <= HAVE2;
               end
            end
            HAVE2: begin
               if (adv)
                  state <= HAVE1;
            end
            HAVE1: begin
               // in_ready == adv here, so in_hs implies the second nibble loads
               if (adv) begin
                  if (in_hs) begin
                     byte_q <= in_data;
                     state  <= HAVE2;
                  end else begin
                     state  <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: doc/qam16_mapper.md
Name: qam16_mapper

Overview:
- Downstream neighbour of the LFSR byte source in the ofdm_16qam_n8_w16_cp4 transmit chain.
- Accepts 8-bit bytes over a valid/ready handshake and splits each byte into two 4-bit nibbles.
- Maps each nibble to a Gray-coded 16-QAM I/Q pair and emits one subcarrier symbol per handshake to the IFFT/CP stage.
- Tags each subcarrier with its index within the OFDM symbol and asserts a last flag on subcarrier NSC-1.

Parameters:
- DW, 16: signed width of each I and Q output sample (two's complement).
- AMP, 4096: unit amplitude A; the four levels are -3A, -A, +A, +3A. 3*AMP must fit in DW signed.
- NSC, 8: subcarriers per OFDM symbol; out_idx wraps at NSC-1.

Ports:
- aclk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- in_data, input, 8: byte from the source.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: mapper accepts a byte this cycle.
- out_i, output, DW: in-phase sample.
- out_q, output, DW: quadrature sample.
- out_idx, output, $clog2(NSC): subcarrier index of the current output.
- out_last, output, 1: high when out_idx == NSC-1.
- out_valid, output, 1: output bundle is valid.
- out_ready, input, 1: downstream accepts the output.

Behaviour:
- Clocking and reset: one clock, aclk. Reset is synchronous and active-high.
- On a reset edge: out_valid=0, out_i=0, out_q=0, out_idx=0, out_last=0, byte buffer empty (state EMPTY).
  - A partially consumed byte is discarded.
  - in_ready is 1 in the cycle after reset deasserts, provided no reset is asserted.
- Handshakes:
  - Input handshake: in_valid && in_ready at a rising edge.
  - Output handshake: out_valid && out_ready.
  - adv = !out_valid || out_ready. The output register loads only when adv is true.
- Buffer FSM:
  - EMPTY: in_ready=1. On input handshake, latch the byte and go to HAVE2.
  - HAVE2: in_ready=0. If adv, load the first nibble into the output register, set out_valid=1, go to HAVE1.
  - HAVE1: in_ready=adv.
    - If adv with no input handshake: load the second nibble and go to EMPTY.
    - If adv with a simultaneous input handshake: load the second nibble, latch the new byte, go to HAVE2.
  - EMPTY with adv: out_valid becomes 0 (bubble). The output is never overwritten while out_valid && !out_ready.
- Latency and throughput:
  - Byte accepted at edge t produces its first symbol on the outputs after edge t+1 (if adv) and its second after edge t+2.
  - Sustained rate is one symbol per cycle, i.e. one byte per 2 cycles.
- Nibble order: high nibble [7:4] first, then [3:0]. See the optional feature.
- Mapping: nibble b3b2b1b0. I uses b3b2 and Q uses b1b0.
  - Gray code: 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A.
  - Levels are computed from constants at elaboration; there is no runtime multiplier.
- Index counter:
  - out_idx and out_last are loaded together with the symbol.
  - The counter advances on every output-register load that follows a completed output handshake, and wraps from NSC-1 to 0.
  - out_idx is constant while the output stalls.
- Stall with out_ready=0: out_i, out_q, out_idx, out_last and out_valid hold. in_ready=0 except in EMPTY.
- Wrap-around: out_last=1 exactly once every NSC accepted symbols. Symbol count is continuous across OFDM symbols with no gaps inserted.

Optional Feature:
- Macro: QAM16_LSB_FIRST_EN.
- Defined: the low nibble [3:0] is emitted first, then [7:4].
- Undefined (default): the high nibble is emitted first.
- Nothing else changes: timing, mapping and ports are identical.

Decomposition:
- Shared package qam16_pkg holds:
  - the Gray level constants LVL_M3, LVL_M1, LVL_P1, LVL_P3 as functions of AMP;
  - the FSM state encoding EMPTY/HAVE2/HAVE1;
  - NSC_DEFAULT and DW_DEFAULT for the chain.
- One natural sub-module, qam16_gray_lut: combinational mapping of a 2-bit pair to a DW-bit level, instantiated twice (I and Q).

Test Plan:
- Reset then single byte 0x0F with out_ready=1 -> symbol 0: I=Q=-12288 (0xD000). Symbol 1: I=Q=+4096. out_idx=0 then 1. in_ready low only in the HAVE2 cycle.
- Byte 0xA5 -> symbol from 0xA: I=+12288, Q=+12288. Symbol from 0x5: I=-4096, Q=-4096. With QAM16_LSB_FIRST_EN the order is reversed.
- Continuous in_valid=1 and out_ready=1 for 4 bytes -> 8 back-to-back symbols with no bubble. out_idx runs 0..7. out_last=1 only on idx 7. The next byte's first symbol has idx 0.
- out_ready=0 for 5 cycles mid-byte (state HAVE1) -> outputs and out_idx frozen, in_ready=0. When released, the low-nibble symbol appears next cycle and no data is lost or duplicated.
- Synchronous reset asserted while in HAVE2 -> next edge gives out_valid=0, out_idx=0, the byte is dropped. The following byte 0xF0 maps to +4096/+4096 then -12288/-12288 with idx 0 and 1.
- Random in_valid/out_ready for 10k cycles against the LFSR source and a reference model -> exact symbol sequence match, and out_last period = 8 accepted symbols.
